// File: rtl/peridot_pfc_ex.sv
// Pin function controller for one pad bank. Each pin selects GPIO, a dedicated function or an aux output onto
// a tri-state pad. Pad input passes through a 2-FF synchroniser, a glitch filter and rise/fall edge interrupt logic.
module peridot_pfc_ex #(
  parameter int          PIN_WIDTH        = 8,
  parameter int          FILTER_LEN       = 4,
  parameter logic [31:0] DEFAULT_PINREGS  = 32'h0000_0000,
  parameter logic [31:0] DEFAULT_FUNCREGS = 32'h0000_0000
) (
  input  logic                 csi_clk,
  input  logic                 rsi_reset,
  input  logic [1:0]           avs_address,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 ins_irq,
  inout  wire  [PIN_WIDTH-1:0] coe_pin,
  output logic [PIN_WIDTH-1:0] coe_pin_through,
  output logic [PIN_WIDTH-1:0] coe_function_din,
  input  logic [7:0]           coe_function_dout,
  input  logic [7:0]           coe_function_oe,
  input  logic [7:0]           coe_function_aux0,
  input  logic [7:0]           coe_function_aux1,
  input  logic [7:0]           coe_function_aux2,
  input  logic [7:0]           coe_function_aux3
);

  localparam logic [7:0]  PMASK    = 8'((16'd1 << PIN_WIDTH) - 16'd1);
  localparam logic [31:0] FMASK    = (PIN_WIDTH >= 8) ? 32'hFFFF_FFFF
                                                      : 32'((64'd1 << (4 * PIN_WIDTH)) - 64'd1);
  localparam logic [3:0]  CNT_LAST = 4'(FILTER_LEN - 1);

  logic [7:0]       pin_out_q, pin_out_d;
  logic [7:0]       pin_oe_q, pin_oe_d;
  logic [31:0]      func_q, func_d;
  logic [7:0]       rise_en_q, rise_en_d;
  logic [7:0]       fall_en_q, fall_en_d;
  logic [7:0]       intstat_q, intstat_d;
  logic             irq_q, irq_d;
  logic [7:0]       s1_q, s1_d;
  logic [7:0]       s2_q, s2_d;
  logic [7:0]       filt_q, filt_d;
  logic [7:0]       filt_dly_q, filt_dly_d;
  logic [7:0][3:0]  cnt_q, cnt_d;

  logic [7:0]       drv_out, drv_oe;
  logic [7:0]       pad_in;
  logic [7:0]       edge_set;
  logic [7:0]       w1c;

  // Pad mux: codes 2,3 and 8-15 leave the pad floating.
  always_comb begin
    drv_out = '0;
    drv_oe  = '0;
    for (int n = 0; n < 8; n++) begin
      case (func_q[4*n +: 4])
        4'd0: begin drv_out[n] = pin_out_q[n];         drv_oe[n] = pin_oe_q[n];         end
        4'd1: begin drv_out[n] = coe_function_dout[n]; drv_oe[n] = coe_function_oe[n]; end
        4'd4: begin drv_out[n] = coe_function_aux0[n]; drv_oe[n] = 1'b1;               end
        4'd5: begin drv_out[n] = coe_function_aux1[n]; drv_oe[n] = 1'b1;               end
        4'd6: begin drv_out[n] = coe_function_aux2[n]; drv_oe[n] = 1'b1;               end
        4'd7: begin drv_out[n] = coe_function_aux3[n]; drv_oe[n] = 1'b1;               end
        default: begin drv_out[n] = 1'b0;              drv_oe[n] = 1'b0;               end
      endcase
    end
    drv_oe = drv_oe & PMASK;
  end

  for (genvar g = 0; g < PIN_WIDTH; g++) begin : g_pad
    assign coe_pin[g] = drv_oe[g] ? drv_out[g] : 1'bz;
  end

  assign pad_in = 8'(coe_pin) & PMASK;

  // Filter: filt follows s2 only after s2 has disagreed for FILTER_LEN consecutive cycles.
  always_comb begin
    s1_d       = pad_in;
    s2_d       = s1_q;
    filt_dly_d = filt_q;
    filt_d     = filt_q;
    cnt_d      = cnt_q;
    for (int n = 0; n < 8; n++) begin
      if (FILTER_LEN == 0) begin
        filt_d[n] = s2_q[n];
        cnt_d[n]  = 4'd0;
      end else if (s2_q[n] == filt_q[n]) begin
        cnt_d[n] = 4'd0;
      end else if (cnt_q[n] == CNT_LAST) begin
        filt_d[n] = s2_q[n];
        cnt_d[n]  = 4'd0;
      end else begin
        cnt_d[n] = cnt_q[n] + 4'd1;
      end
    end
  end

  // A new edge outranks a simultaneous write-1-to-clear.
  always_comb begin
    edge_set  = ((filt_q & ~filt_dly_q & rise_en_q) | (~filt_q & filt_dly_q & fall_en_q)) & PMASK;
    w1c       = (avs_write && avs_address == 2'd3) ? avs_writedata[7:0] : 8'h00;
    intstat_d = (intstat_q & ~w1c) | edge_set;
    irq_d     = |intstat_q;
  end

  always_comb begin
    pin_out_d = pin_out_q;
    pin_oe_d  = pin_oe_q;
    func_d    = func_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (avs_write) begin
      case (avs_address)
        2'd0: begin
          pin_out_d = avs_writedata[7:0] & PMASK;
          pin_oe_d  = avs_writedata[15:8] & PMASK;
        end
        2'd1: func_d = avs_writedata & FMASK;
        2'd2: begin
          rise_en_d = avs_writedata[7:0] & PMASK;
          fall_en_d = avs_writedata[15:8] & PMASK;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      pin_out_q  <= DEFAULT_PINREGS[7:0] & PMASK;
      pin_oe_q   <= DEFAULT_PINREGS[15:8] & PMASK;
      func_q     <= DEFAULT_FUNCREGS & FMASK;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      intstat_q  <= '0;
      irq_q      <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      cnt_q      <= '0;
    end else begin
      pin_out_q  <= pin_out_d;
      pin_oe_q   <= pin_oe_d;
      func_q     <= func_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      intstat_q  <= intstat_d;
      irq_q      <= irq_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_dly_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    case (avs_address)
      2'd0:    avs_readdata = {8'h00, filt_q, pin_oe_q, pin_out_q};
      2'd1:    avs_readdata = func_q;
      2'd2:    avs_readdata = {16'h0000, fall_en_q, rise_en_q};
      default: avs_readdata = {24'h000000, intstat_q};
    endcase
  end

  assign ins_irq          = irq_q;
  assign coe_pin_through  = filt_q[PIN_WIDTH-1:0];
  assign coe_function_din = s2_q[PIN_WIDTH-1:0];

endmodule

// File: tb/tb_peridot_pfc_ex.sv
// Bench for peridot_pfc_ex: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a window-based behavioural model of the pin bank.
module tb_peridot_pfc_ex;
  localparam int FL = 4;

  logic        csi_clk = 1'b0;
  logic        rsi_reset = 1'b1;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'h0;
  logic [31:0] avs_readdata;
  logic        ins_irq;
  wire  [7:0]  coe_pin;
  logic [7:0]  coe_pin_through, coe_function_din;
  logic [7:0]  coe_function_dout = 8'h10, coe_function_oe = 8'h30;
  logic [7:0]  coe_function_aux0 = 8'h00, coe_function_aux1 = 8'h00;
  logic [7:0]  coe_function_aux2 = 8'h00, coe_function_aux3 = 8'h00;
  logic [7:0]  tb_en = 8'h00, tb_val = 8'h00;

  int nchk = 0;
  int nfail = 0;
  logic chk_on = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign coe_pin[i] = tb_en[i] ? tb_val[i] : 1'bz;
    pulldown (coe_pin[i]);
  end

  always #5 csi_clk = ~csi_clk;

  peridot_pfc_ex #(
    .PIN_WIDTH(8), .FILTER_LEN(FL),
    .DEFAULT_PINREGS(32'h0000_0000), .DEFAULT_FUNCREGS(32'h0011_0000)
  ) dut (
    .csi_clk(csi_clk), .rsi_reset(rsi_reset),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .ins_irq(ins_irq),
    .coe_pin(coe_pin), .coe_pin_through(coe_pin_through), .coe_function_din(coe_function_din),
    .coe_function_dout(coe_function_dout), .coe_function_oe(coe_function_oe),
    .coe_function_aux0(coe_function_aux0), .coe_function_aux1(coe_function_aux1),
    .coe_function_aux2(coe_function_aux2), .coe_function_aux3(coe_function_aux3)
  );

  // ---------------- behavioural model ----------------
  logic [7:0]  m_pout = 0, m_poe = 0, m_ren = 0, m_fen = 0, m_ist = 0;
  logic [31:0] m_func = 0;
  logic        m_irq = 0;
  logic [7:0]  m_s1 = 0, m_s2 = 0, m_filt = 0, m_fd = 0;
  logic [15:0] hist [8];
  logic [7:0]  pad_s, set_v, clr_v, nf;
  logic [15:0] wmask;

  function automatic logic [7:0] exp_oe();
    logic [7:0] r = 8'h00;
    for (int p = 0; p < 8; p++) begin
      int code = int'(m_func[4*p +: 4]);
      if (code == 0)                  r[p] = m_poe[p];
      else if (code == 1)             r[p] = coe_function_oe[p];
      else if (code >= 4 && code < 8) r[p] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_out();
    logic [7:0] r = 8'h00;
    logic [7:0] ax [4];
    ax[0] = coe_function_aux0; ax[1] = coe_function_aux1;
    ax[2] = coe_function_aux2; ax[3] = coe_function_aux3;
    for (int p = 0; p < 8; p++) begin
      int code = int'(m_func[4*p +: 4]);
      if (code == 0)                  r[p] = m_pout[p];
      else if (code == 1)             r[p] = coe_function_dout[p];
      else if (code >= 4 && code < 8) r[p] = ax[code-4][p];
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_pad();
    logic [7:0] oe = exp_oe();
    return (oe & exp_out()) | (~oe & tb_en & tb_val);
  endfunction

  function automatic logic [31:0] exp_rd();
    case (avs_address)
      2'd0:    return {8'h00, m_filt, m_poe, m_pout};
      2'd1:    return m_func;
      2'd2:    return {16'h0000, m_fen, m_ren};
      default: return {24'h000000, m_ist};
    endcase
  endfunction

  always @(posedge csi_clk) begin
    pad_s = exp_pad();
    wmask = 16'((17'd1 << FL) - 17'd1);
    if (rsi_reset) begin
      m_pout = 8'h00; m_poe = 8'h00; m_func = 32'h0011_0000;
      m_ren = 0; m_fen = 0; m_ist = 0; m_irq = 0;
      m_s1 = 0; m_s2 = 0; m_filt = 0; m_fd = 0;
      for (int p = 0; p < 8; p++) hist[p] = 16'h0;
    end else begin
      set_v = 8'h00;
      for (int p = 0; p < 8; p++) begin
        if (m_filt[p] && !m_fd[p] && m_ren[p]) set_v[p] = 1'b1;
        if (!m_filt[p] && m_fd[p] && m_fen[p]) set_v[p] = 1'b1;
      end
      clr_v = (avs_write && avs_address == 2'd3) ? avs_writedata[7:0] : 8'h00;
      m_irq = (m_ist != 8'h00);
      m_ist = (m_ist & ~clr_v) | set_v;
      // filt flips once the last FL synchronised samples all disagree with it
      for (int p = 0; p < 8; p++) begin
        hist[p] = {hist[p][14:0], m_s2[p]};
        if (FL == 0) nf[p] = m_s2[p];
        else if ((hist[p] & wmask) == (m_filt[p] ? 16'h0000 : wmask)) nf[p] = ~m_filt[p];
        else nf[p] = m_filt[p];
      end
      m_fd = m_filt; m_filt = nf; m_s2 = m_s1; m_s1 = pad_s;
      if (avs_write) begin
        case (avs_address)
          2'd0: begin m_pout = avs_writedata[7:0]; m_poe = avs_writedata[15:8]; end
          2'd1: m_func = avs_writedata;
          2'd2: begin m_ren = avs_writedata[7:0]; m_fen = avs_writedata[15:8]; end
          default: ;
        endcase
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge csi_clk) begin
    if (chk_on) begin
      check("model_rdata", avs_readdata, exp_rd());
      check("model_irq", 32'(ins_irq), 32'(m_irq));
      check("model_through", 32'(coe_pin_through), 32'(m_filt));
      check("model_din", 32'(coe_function_din), 32'(m_s2));
      check("model_pad", 32'(coe_pin), 32'(exp_pad()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge csi_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    cyc();
    avs_write = 1'b0;
  endtask

  logic seen;

  initial begin
    cyc();
    chk_on = 1'b1;
    cyc();
    rsi_reset = 1'b0;
    avs_address = 2'd1;
    #1;
    check("reset_funcreg", avs_readdata, 32'h0011_0000);
    check("reset_pads_dedicated", 32'(coe_pin), 32'h10);
    avs_address = 2'd0;
    #1;
    check("reset_pinreg", avs_readdata, 32'h0);

    wr(2'd1, 32'h0);
    wr(2'd0, 32'h0000_FF5A);
    check("gpio_pads_5a", 32'(coe_pin), 32'h5A);
    wr(2'd0, 32'h0000_00FF);
    check("gpio_pads_z", 32'(coe_pin), 32'h00);

    // glitch filter on pin0
    tb_en = 8'h01; tb_val = 8'h00;
    repeat (8) cyc();
    tb_val[0] = 1'b1;
    repeat (3) cyc();
    tb_val[0] = 1'b0;
    seen = 1'b0;
    repeat (10) begin cyc(); seen |= coe_pin_through[0]; end
    check("short_pulse_blocked", 32'(seen), 32'h0);
    tb_val[0] = 1'b1;
    repeat (4) cyc();
    tb_val[0] = 1'b0;
    cyc();
    check("pulse_before_6", 32'(coe_pin_through[0]), 32'h0);
    cyc();
    check("pulse_at_6", 32'(coe_pin_through[0]), 32'h1);
    repeat (8) cyc();
    check("pulse_fell", 32'(coe_pin_through[0]), 32'h0);

    // edge interrupts
    wr(2'd2, 32'h0000_0101);
    avs_address = 2'd3;
    tb_val[0] = 1'b1;
    repeat (7) cyc();
    check("rise_intstat", avs_readdata, 32'h1);
    check("rise_irq_lag", 32'(ins_irq), 32'h0);
    cyc();
    check("rise_irq", 32'(ins_irq), 32'h1);
    wr(2'd3, 32'h1);
    check("w1c_intstat", avs_readdata, 32'h0);
    cyc();
    check("w1c_irq", 32'(ins_irq), 32'h0);
    tb_val[0] = 1'b0;
    repeat (7) cyc();
    check("fall_intstat", avs_readdata, 32'h1);
    check("fall_irq_lag", 32'(ins_irq), 32'h0);
    cyc();
    check("fall_irq", 32'(ins_irq), 32'h1);

    // set vs clear collision
    tb_val[0] = 1'b1;
    repeat (6) cyc();
    check("collide_filt", 32'(coe_pin_through[0]), 32'h1);
    wr(2'd3, 32'h1);
    check("set_wins", avs_readdata, 32'h1);
    cyc();
    check("set_wins_irq", 32'(ins_irq), 32'h1);

    // aux select and hi-z code
    coe_function_aux2 = 8'h08;
    wr(2'd1, 32'h0000_6000);
    check("aux2_pad3", 32'(coe_pin), 32'h09);
    wr(2'd1, 32'h0000_9000);
    check("code9_pad3_z", 32'(coe_pin), 32'h01);

    // reset while the filter is counting
    avs_address = 2'd3;
    tb_val[0] = 1'b0;
    repeat (3) cyc();
    rsi_reset = 1'b1;
    cyc();
    rsi_reset = 1'b0;
    check("rst_filt", 32'(coe_pin_through), 32'h0);
    check("rst_irq", 32'(ins_irq), 32'h0);
    check("rst_intstat", avs_readdata, 32'h0);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      rsi_reset = ($urandom_range(0, 599) == 0);
      avs_address = 2'($urandom_range(0, 3));
      avs_write = ($urandom_range(0, 7) == 0);
      avs_writedata = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        coe_function_dout = 8'($urandom); coe_function_oe = 8'($urandom);
        coe_function_aux0 = 8'($urandom); coe_function_aux1 = 8'($urandom);
        coe_function_aux2 = 8'($urandom); coe_function_aux3 = 8'($urandom);
      end
      for (int p = 0; p < 8; p++)
        if ($urandom_range(0, 5) == 0) tb_val[p] = ~tb_val[p];
      tb_en = ~exp_oe();
      cyc();
    end
    avs_write = 1'b0;
    rsi_reset = 1'b0;
    cyc();
    chk_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
